regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWr/RW/BusW) between two writeback requesters: port 0 = ALU writeback, port 1 = load/memory writeback.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Presents a registered write command that the register file captures at the following negedge of Clk.
- Keeps saturating per-port grant counters and a dropped-R0-write counter for performance debug.

Parameters:
DW, 32, data width of BusW and request data
AW, 5, register address width (32 registers)
CW, 16, width of each statistics counter

Ports:
Clk  input  1  clock; all state updates on posedge
Resetn  input  1  asynchronous, active-low reset
Req0Valid  input  1  port 0 (ALU) has a write pending
Req0Ready  output  1  port 0 request accepted this cycle
Req0RW  input  AW  port 0 destination register
Req0Data  input  DW  port 0 write data
Req1Valid  input  1  port 1 (load) has a write pending
Req1Ready  output  1  port 1 request accepted this cycle
Req1RW  input  AW  port 1 destination register
Req1Data  input  DW  port 1 write data
CntClr  input  1  synchronous clear of all counters
RegWr  output  1  register-file write enable (registered)
RW  output  AW  register-file write address (registered)
BusW  output  DW  register-file write data (registered)
GntCnt0  output  CW  grants issued to port 0, saturating
GntCnt1  output  CW  grants issued to port 1, saturating
DropCnt  output  CW  accepted writes to R0, saturating

Behaviour:
- Reset: Clk drives a single clock domain. Resetn is asynchronous and active-low.
- Reset values: RegWr=0, RW=0, BusW=0, all counters=0, round-robin pointer Last=1 (port 0 wins the first tie).
- While Resetn=0, Req0Ready and Req1Ready are forced to 0.
- No downstream backpressure: the register file accepts one write every cycle, so a grant is issued whenever any request is valid.
- Grant (combinational from inputs and Last):
  - Only one valid: that port is granted.
  - Both valid: the port != Last is granted.
  - Neither valid: no grant.
- ReqXReady = grantX. A handshake completes when Valid && Ready at a posedge. Requesters must hold Valid, RW and Data stable until Ready.
- Last is updated to the winning port on every grant and holds otherwise. With both ports continuously valid, grants strictly alternate, so maximum wait is 1 cycle.
- Output stage, at the posedge where port X is granted:
  - If ReqXRW != 0: RegWr<=1, RW<=ReqXRW, BusW<=ReqXData.
  - If ReqXRW == 0: RegWr<=0, RW and BusW hold, DropCnt increments. The handshake still completes.
- No grant: RegWr<=0; RW and BusW hold their values.
- Latency: request accepted at posedge N → RegWr high from N to N+1 → register file writes at the negedge inside that cycle. The value is readable from the second half of that cycle onward.
- Same destination on both ports in the same cycle: the round-robin winner writes first, the loser writes next cycle, so the loser's data is final. Program-order resolution is the requesters' responsibility.
- Counters: the granted port's GntCnt increments by 1 and sticks at 2^CW-1. CntClr=1 zeroes all three counters; clear takes priority over increment in the same cycle.
- Reset asserted mid-operation: the registered write is cancelled immediately (RegWr=0), pending requests see no Ready, and Last returns to 1.

Decomposition:
- Shared package regfile_pkg:
  - constants: DATA_W=32, REG_AW=5, REG_ZERO=5'd0
  - port index constants: PORT_ALU=0, PORT_LOAD=1
- Sub-module rr_arb2: two-request round-robin arbiter.
  - inputs: req[1:0]
  - outputs: gnt[1:0] (one-hot or zero)
  - contains the Last pointer and its async reset
- Counter saturation logic stays inline.

Test Plan:
- Reset: drive Resetn=0 mid-cycle while RegWr=1 → RegWr, RW, BusW and all counters read 0 immediately; Ready=0 throughout reset.
- Single port: Req0 writes R5=0xDEADBEEF → Req0Ready=1 that cycle; next cycle RegWr=1, RW=5, BusW=0xDEADBEEF; GntCnt0=1.
- Contention: both ports valid every cycle for 6 cycles (port 0 RW=1..6, port 1 RW=11..16) → grant order 0,1,0,1,0,1; GntCnt0=GntCnt1=3; no request waits more than 1 cycle.
- R0 drop: Req1 writes R0=0x1234 → Req1Ready=1; RegWr stays 0 and RW/BusW unchanged next cycle; DropCnt=1; GntCnt1=1.
- Same target: both ports write R7 with port 0 data 0xA and port 1 data 0xB, Last=1 → port 0 writes at cycle N+1 and port 1 at N+2; the register file holds 0xB.
- Counters: with CW=4, grant port 0 20 times → GntCnt0=15 (saturated); CntClr asserted in the same cycle as a grant → GntCnt0=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: default widths,
// the hard-wired zero register and the requester port indices.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam int PORT_ALU  = 0;
  localparam int PORT_LOAD = 1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready requesters on one side, the registered
// register-file write port on the other.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) ();

  logic          Req0Valid;
  logic          Req0Ready;
  logic [AW-1:0] Req0RW;
  logic [DW-1:0] Req0Data;

  logic          Req1Valid;
  logic          Req1Ready;
  logic [AW-1:0] Req1RW;
  logic [DW-1:0] Req1Data;

  logic          RegWr;
  logic [AW-1:0] RW;
  logic [DW-1:0] BusW;

  // Requesters and register file together form the master side.
  modport master (
    output Req0Valid, Req0RW, Req0Data,
    output Req1Valid, Req1RW, Req1Data,
    input  Req0Ready, Req1Ready,
    input  RegWr, RW, BusW
  );

  modport slave (
    input  Req0Valid, Req0RW, Req0Data,
    input  Req1Valid, Req1RW, Req1Data,
    output Req0Ready, Req1Ready,
    output RegWr, RW, BusW
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-request round-robin arbiter. Last remembers the previous winner so a
// tie goes to the other port; it resets to the load port so ALU wins first.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_last;

  always_comb begin
    gnt            = 2'b00;
    gnt[PORT_ALU]  = req[PORT_ALU]  & (~req[PORT_LOAD] |  r_last);
    gnt[PORT_LOAD] = req[PORT_LOAD] & (~req[PORT_ALU]  | ~r_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|gnt) begin
      r_last <= gnt[PORT_LOAD];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback with
// round-robin arbitration, plus saturating grant and dropped-R0 counters.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW,
  parameter int CW = 16
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  regfile_wb_arbiter_if.slave   bus,
  input  logic                  CntClr,
  output logic [CW-1:0]         GntCnt0,
  output logic [CW-1:0]         GntCnt1,
  output logic [CW-1:0]         DropCnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_grant;
  logic          w_drop;
  logic [AW-1:0] w_selRW;
  logic [DW-1:0] w_selData;

  logic          r_regWr;
  logic [AW-1:0] r_rw;
  logic [DW-1:0] r_busW;
  logic [CW-1:0] r_gntCnt0;
  logic [CW-1:0] r_gntCnt1;
  logic [CW-1:0] r_dropCnt;

  // Masking with Resetn keeps Ready low for the whole reset window.
  assign w_req = {bus.Req1Valid, bus.Req0Valid} & {2{Resetn}};

  rr_arb2 u_arb (
    .clk   (Clk),
    .rst_n (Resetn),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign bus.Req0Ready = w_gnt[PORT_ALU];
  assign bus.Req1Ready = w_gnt[PORT_LOAD];

  assign w_grant   = |w_gnt;
  assign w_selRW   = w_gnt[PORT_LOAD] ? bus.Req1RW   : bus.Req0RW;
  assign w_selData = w_gnt[PORT_LOAD] ? bus.Req1Data : bus.Req0Data;
  assign w_drop    = w_grant && (w_selRW == AW'(REG_ZERO));

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_regWr <= 1'b0;
      r_rw    <= '0;
      r_busW  <= '0;
    end else if (w_grant && !w_drop) begin
      r_regWr <= 1'b1;
      r_rw    <= w_selRW;
      r_busW  <= w_selData;
    end else begin
      r_regWr <= 1'b0;
    end
  end

  // Clear beats increment; each counter sticks at all-ones.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_gntCnt0 <= '0;
      r_gntCnt1 <= '0;
      r_dropCnt <= '0;
    end else if (CntClr) begin
      r_gntCnt0 <= '0;
      r_gntCnt1 <= '0;
      r_dropCnt <= '0;
    end else begin
      if (w_gnt[PORT_ALU] && (r_gntCnt0 != CNT_MAX)) begin
        r_gntCnt0 <= r_gntCnt0 + 1'b1;
      end
      if (w_gnt[PORT_LOAD] && (r_gntCnt1 != CNT_MAX)) begin
        r_gntCnt1 <= r_gntCnt1 + 1'b1;
      end
      if (w_drop && (r_dropCnt != CNT_MAX)) begin
        r_dropCnt <= r_dropCnt + 1'b1;
      end
    end
  end

  assign bus.RegWr = r_regWr;
  assign bus.RW    = r_rw;
  assign bus.BusW  = r_busW;
  assign GntCnt0   = r_gntCnt0;
  assign GntCnt1   = r_gntCnt1;
  assign DropCnt   = r_dropCnt;

endmodule
